// File: rtl/hazard_control_unit.sv
// Pipeline hazard control: detects load-use hazards and inserts LOAD_LAT
// bubbles, flushes IF/ID and ID/EX on taken branches, and freezes the back
// end of the pipe while data memory is busy. Stall_Count is a saturating
// count of lost cycles (bubbles plus freezes).
module hazard_control_unit #(
  parameter int REG_W     = 5,
  parameter int LOAD_LAT  = 1,
  parameter int CNT_W     = 16,
  parameter int ZERO_SKIP = 1
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic [REG_W-1:0] IF_ID_Rs,
  input  logic [REG_W-1:0] IF_ID_Rt,
  input  logic             IF_ID_UsesRt,
  input  logic             ID_EXE_MemRead,
  input  logic [REG_W-1:0] ID_EXE_RtReg,
  input  logic             Branch_Taken,
  input  logic             Mem_Ready,
  input  logic             Clear_Count,
  output logic             Stall,
  output logic             PC_Write,
  output logic             IF_ID_Write,
  output logic             IF_ID_Flush,
  output logic             ID_EXE_Flush,
  output logic             Pipe_Freeze,
  output logic [CNT_W-1:0] Stall_Count
);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    MEM_WAIT   = 2'd2
  } state_t;

  // Bubble counter holds at most LOAD_LAT-1 = 7.
  localparam int               BUB_W    = 4;
  localparam logic [BUB_W-1:0] BUB_INIT = BUB_W'(LOAD_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t           state;
  state_t           ret_state;   // state to resume once memory is ready
  state_t           resume_state;
  logic [BUB_W-1:0] bub_cnt;
  logic             rt_match;
  logic             zero_mask;
  logic             hazard;

  // Load-use hazard: the load in ID/EX writes a register the IF/ID
  // instruction reads. Register 0 is hardwired, so it can be masked.
  assign rt_match  = (ID_EXE_RtReg == IF_ID_Rs) ||
                     (IF_ID_UsesRt && (ID_EXE_RtReg == IF_ID_Rt));
  assign zero_mask = (ZERO_SKIP != 0) && (ID_EXE_RtReg == '0);
  assign hazard    = ID_EXE_MemRead && rt_match && !zero_mask;

  // While waiting on memory, behave as the interrupted state the moment
  // Mem_Ready returns, so no cycle is lost on the way out.
  assign resume_state = (state == MEM_WAIT) ? ret_state : state;

  // Output decode in priority order: memory wait, branch, load stall, normal.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    Stall        = 1'b0;
    PC_Write     = 1'b1;
    IF_ID_Write  = 1'b1;
    IF_ID_Flush  = 1'b0;
    ID_EXE_Flush = 1'b0;
    Pipe_Freeze  = 1'b0;
    // Outputs stay at their idle values while reset is held.
    if (Reset_n) begin
      if (!Mem_Ready) begin
        Pipe_Freeze = 1'b1;
        PC_Write    = 1'b0;
        IF_ID_Write = 1'b0;
      end else if (Branch_Taken) begin
        IF_ID_Flush  = 1'b1;
        ID_EXE_Flush = 1'b1;
      end else if ((resume_state == LOAD_STALL) || hazard) begin
        Stall       = 1'b1;
        PC_Write    = 1'b0;
        IF_ID_Write = 1'b0;
      end
    end
  end

  // State and bubble-counter sequencing.
  always_ff @(posedge Clk or negedge Reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!Reset_n) begin
      state     <= RUN;
      ret_state <= RUN;
      bub_cnt   <= '0;
    end else if (!Mem_Ready) begin
      // Remember only the first state entered from; the bubble count holds.
      if (state != MEM_WAIT) begin
        ret_state <= state;
      end
      state <= MEM_WAIT;
    end else if (Branch_Taken) begin
      // The stalled instruction is being flushed, so its stall is moot.
      state   <= RUN;
      bub_cnt <= '0;
    end else if (resume_state == LOAD_STALL) begin
      bub_cnt <= bub_cnt - BUB_W'(1);
      state   <= (bub_cnt <= BUB_W'(1)) ? RUN : LOAD_STALL;
    end else if (hazard && (LOAD_LAT > 1)) begin
      // The hazard cycle itself is the first bubble.
      bub_cnt <= BUB_INIT;
      state   <= LOAD_STALL;
    end else begin
      state <= RUN;
    end
  end

  // Saturating lost-cycle counter; a clear request beats the increment.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      Stall_Count <= '0;
    end else if (Clear_Count) begin
      Stall_Count <= '0;
    end else if ((Stall || Pipe_Freeze) && (Stall_Count != CNT_MAX)) begin
      Stall_Count <= Stall_Count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_control_unit.sv
// Self-checking bench for hazard_control_unit. Four instances share one
// stimulus stream: 0 = defaults (LOAD_LAT=1), 1 = LOAD_LAT=3,
// 2 = ZERO_SKIP=0, 3 = CNT_W=4. Expected outputs are queued as each cycle's
// inputs are driven and compared just after the falling edge.
module tb_hazard_control_unit;

  typedef struct packed {
    logic       mr;
    logic [4:0] rtreg;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       ur;
    logic       br;
    logic       rdy;
    logic       clr;
  } stim_t;

  typedef struct {
    int          sel;
    logic [5:0]  flags;
    logic [15:0] cnt;
    string       name;
  } exp_t;

  // {Stall, PC_Write, IF_ID_Write, IF_ID_Flush, ID_EXE_Flush, Pipe_Freeze}
  localparam logic [5:0] NORM_F   = 6'b011000;
  localparam logic [5:0] STALL_F  = 6'b100000;
  localparam logic [5:0] FREEZE_F = 6'b000001;
  localparam logic [5:0] FLUSH_F  = 6'b011110;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic [4:0] IF_ID_Rs = '0;
  logic [4:0] IF_ID_Rt = '0;
  logic       IF_ID_UsesRt = 1'b0;
  logic       ID_EXE_MemRead = 1'b0;
  logic [4:0] ID_EXE_RtReg = '0;
  logic       Branch_Taken = 1'b0;
  logic       Mem_Ready = 1'b1;
  logic       Clear_Count = 1'b0;

  logic [5:0]  obs_flags [4];
  logic [15:0] obs_cnt   [4];

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 Clk = ~Clk;

  for (genvar gi = 0; gi < 4; gi++) begin : g_dut
    localparam int CW = (gi == 3) ? 4 : 16;
    logic          stall, pc_write, ifid_write, ifid_flush, idex_flush, freeze;
    logic [CW-1:0] cnt;

    hazard_control_unit #(
      .REG_W    (5),
      .LOAD_LAT ((gi == 1) ? 3 : 1),
      .CNT_W    (CW),
      .ZERO_SKIP((gi == 2) ? 0 : 1)
    ) dut (
      .Clk           (Clk),
      .Reset_n       (Reset_n),
      .IF_ID_Rs      (IF_ID_Rs),
      .IF_ID_Rt      (IF_ID_Rt),
      .IF_ID_UsesRt  (IF_ID_UsesRt),
      .ID_EXE_MemRead(ID_EXE_MemRead),
      .ID_EXE_RtReg  (ID_EXE_RtReg),
      .Branch_Taken  (Branch_Taken),
      .Mem_Ready     (Mem_Ready),
      .Clear_Count   (Clear_Count),
      .Stall         (stall),
      .PC_Write      (pc_write),
      .IF_ID_Write   (ifid_write),
      .IF_ID_Flush   (ifid_flush),
      .ID_EXE_Flush  (idex_flush),
      .Pipe_Freeze   (freeze),
      .Stall_Count   (cnt)
    );

    assign obs_flags[gi] = {stall, pc_write, ifid_write, ifid_flush, idex_flush, freeze};
    assign obs_cnt[gi]   = 16'(cnt);
  end

  function automatic stim_t mk(input logic mr, input logic [4:0] rtreg,
                               input logic [4:0] rs, input logic [4:0] rt,
                               input logic ur, input logic br,
                               input logic rdy, input logic clr);
    mk = '{mr, rtreg, rs, rt, ur, br, rdy, clr};
  endfunction

  function automatic stim_t idle();
    idle = mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
  endfunction

  // Apply one cycle of inputs just after the falling edge.
  task automatic drive(input stim_t s);
    @(negedge Clk);
    ID_EXE_MemRead = s.mr;
    ID_EXE_RtReg   = s.rtreg;
    IF_ID_Rs       = s.rs;
    IF_ID_Rt       = s.rt;
    IF_ID_UsesRt   = s.ur;
    Branch_Taken   = s.br;
    Mem_Ready      = s.rdy;
    Clear_Count    = s.clr;
  endtask

  task automatic push(input int sel, input logic [5:0] f, input logic [15:0] c,
                      input string nm);
    exp_q.push_back('{sel, f, c, nm});
  endtask

  task automatic do_reset();
    drive(idle());
    Reset_n = 1'b0;
    drive(idle());
    Reset_n = 1'b1;
  endtask

  task automatic test_reset();
    exp_t e;
    Reset_n = 1'b0;
    drive(mk(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0));
    for (int d = 0; d < 4; d++) push(d, NORM_F, 16'd0, "reset_hold");
    #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_flags[e.sel] !== e.flags) begin
        failures++;
        $display("FAIL %s dut%0d flags got=%b want=%b", e.name, e.sel, obs_flags[e.sel], e.flags);
      end
      checks++;
      if (obs_cnt[e.sel] !== e.cnt) begin
        failures++;
        $display("FAIL %s dut%0d count got=%0d want=%0d", e.name, e.sel, obs_cnt[e.sel], e.cnt);
      end
    end
    drive(idle());
    Reset_n = 1'b1;
    for (int d = 0; d < 4; d++) push(d, NORM_F, 16'd0, "reset_release");
    #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_flags[e.sel] !== e.flags) begin
        failures++;
        $display("FAIL %s dut%0d flags got=%b want=%b", e.name, e.sel, obs_flags[e.sel], e.flags);
      end
      checks++;
      if (obs_cnt[e.sel] !== e.cnt) begin
        failures++;
        $display("FAIL %s dut%0d count got=%0d want=%0d", e.name, e.sel, obs_cnt[e.sel], e.cnt);
      end
    end
  endtask

  task automatic test_load_lat1();
    stim_t       st [7];
    logic [5:0]  ef [7];
    logic [15:0] ec [7];
    exp_t        e;
    do_reset();
    st = '{mk(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0), idle(), idle(),
           mk(1'b1, 5'd9, 5'd3, 5'd9, 1'b1, 1'b0, 1'b1, 1'b0), idle(),
           mk(1'b1, 5'd9, 5'd3, 5'd9, 1'b0, 1'b0, 1'b1, 1'b0),
           mk(1'b0, 5'd5, 5'd5, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0)};
    ef = '{STALL_F, NORM_F, NORM_F, STALL_F, NORM_F, NORM_F, NORM_F};
    ec = '{16'd0, 16'd1, 16'd1, 16'd1, 16'd2, 16'd2, 16'd2};
    for (int i = 0; i < 7; i++) begin
      drive(st[i]);
      push(0, ef[i], ec[i], $sformatf("lat1[%0d]", i));
      #1;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (obs_flags[e.sel] !== e.flags) begin
          failures++;
          $display("FAIL %s dut%0d flags got=%b want=%b", e.name, e.sel, obs_flags[e.sel], e.flags);
        end
        checks++;
        if (obs_cnt[e.sel] !== e.cnt) begin
          failures++;
          $display("FAIL %s dut%0d count got=%0d want=%0d", e.name, e.sel, obs_cnt[e.sel], e.cnt);
        end
      end
    end
  endtask

  // The bubble means ID/EX no longer holds the load after the hazard cycle.
  task automatic test_load_lat3();
    stim_t       st [6];
    logic [5:0]  ef [6];
    logic [15:0] ec [6];
    exp_t        e;
    do_reset();
    st = '{mk(1'b1, 5'd7, 5'd2, 5'd7, 1'b1, 1'b0, 1'b1, 1'b0), idle(), idle(), idle(),
           mk(1'b1, 5'd7, 5'd2, 5'd7, 1'b0, 1'b0, 1'b1, 1'b0), idle()};
    ef = '{STALL_F, STALL_F, STALL_F, NORM_F, NORM_F, NORM_F};
    ec = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd3, 16'd3};
    for (int i = 0; i < 6; i++) begin
      drive(st[i]);
      push(1, ef[i], ec[i], $sformatf("lat3[%0d]", i));
      #1;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (obs_flags[e.sel] !== e.flags) begin
          failures++;
          $display("FAIL %s dut%0d flags got=%b want=%b", e.name, e.sel, obs_flags[e.sel], e.flags);
        end
        checks++;
        if (obs_cnt[e.sel] !== e.cnt) begin
          failures++;
          $display("FAIL %s dut%0d count got=%0d want=%0d", e.name, e.sel, obs_cnt[e.sel], e.cnt);
        end
      end
    end
  endtask

  task automatic test_zero_skip();
    stim_t       st [3];
    logic [5:0]  fa [3];
    logic [5:0]  fc [3];
    logic [15:0] ca [3];
    logic [15:0] cc [3];
    exp_t        e;
    do_reset();
    st = '{mk(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0), idle(),
           mk(1'b1, 5'd0, 5'd4, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0)};
    fa = '{NORM_F, NORM_F, NORM_F};
    ca = '{16'd0, 16'd0, 16'd0};
    fc = '{STALL_F, NORM_F, STALL_F};
    cc = '{16'd0, 16'd1, 16'd1};
    for (int i = 0; i < 3; i++) begin
      drive(st[i]);
      push(0, fa[i], ca[i], $sformatf("zskip_on[%0d]", i));
      push(2, fc[i], cc[i], $sformatf("zskip_off[%0d]", i));
      #1;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (obs_flags[e.sel] !== e.flags) begin
          failures++;
          $display("FAIL %s dut%0d flags got=%b want=%b", e.name, e.sel, obs_flags[e.sel], e.flags);
        end
        checks++;
        if (obs_cnt[e.sel] !== e.cnt) begin
          failures++;
          $display("FAIL %s dut%0d count got=%0d want=%0d", e.name, e.sel, obs_cnt[e.sel], e.cnt);
        end
      end
    end
  endtask

  // Memory stalls for two cycles during the second bubble of a 3-cycle
  // load stall, then a branch arrives while memory is still busy.
  task automatic test_mem_wait();
    stim_t       st [8];
    logic [5:0]  ef [8];
    logic [15:0] ec [8];
    exp_t        e;
    do_reset();
    st = '{mk(1'b1, 5'd7, 5'd7, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0),
           mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0),
           mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0),
           idle(), idle(), idle(),
           mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0), idle()};
    ef = '{STALL_F, FREEZE_F, FREEZE_F, STALL_F, STALL_F, NORM_F, FREEZE_F, NORM_F};
    ec = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd5, 16'd6};
    for (int i = 0; i < 8; i++) begin
      drive(st[i]);
      push(1, ef[i], ec[i], $sformatf("memwait[%0d]", i));
      #1;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (obs_flags[e.sel] !== e.flags) begin
          failures++;
          $display("FAIL %s dut%0d flags got=%b want=%b", e.name, e.sel, obs_flags[e.sel], e.flags);
        end
        checks++;
        if (obs_cnt[e.sel] !== e.cnt) begin
          failures++;
          $display("FAIL %s dut%0d count got=%0d want=%0d", e.name, e.sel, obs_cnt[e.sel], e.cnt);
        end
      end
    end
  endtask

  task automatic test_branch();
    stim_t       st [5];
    logic [5:0]  ef [5];
    logic [15:0] ec [5];
    exp_t        e;
    do_reset();
    st = '{mk(1'b1, 5'd7, 5'd7, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0),
           mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0), idle(),
           mk(1'b1, 5'd7, 5'd7, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0), idle()};
    ef = '{STALL_F, FLUSH_F, NORM_F, FLUSH_F, NORM_F};
    ec = '{16'd0, 16'd1, 16'd1, 16'd1, 16'd1};
    for (int i = 0; i < 5; i++) begin
      drive(st[i]);
      push(1, ef[i], ec[i], $sformatf("branch[%0d]", i));
      #1;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (obs_flags[e.sel] !== e.flags) begin
          failures++;
          $display("FAIL %s dut%0d flags got=%b want=%b", e.name, e.sel, obs_flags[e.sel], e.flags);
        end
        checks++;
        if (obs_cnt[e.sel] !== e.cnt) begin
          failures++;
          $display("FAIL %s dut%0d count got=%0d want=%0d", e.name, e.sel, obs_cnt[e.sel], e.cnt);
        end
      end
    end
  endtask

  // 4-bit counter saturation, clear priority, then async reset mid-stall.
  task automatic test_saturate();
    stim_t haz;
    exp_t  e;
    haz = mk(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    do_reset();
    for (int i = 0; i < 23; i++) begin
      if (i == 20) drive(mk(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1));
      else drive(haz);
      push(3, STALL_F, (i < 21) ? 16'((i > 15) ? 15 : i) : 16'(i - 21),
           $sformatf("sat[%0d]", i));
      #1;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (obs_flags[e.sel] !== e.flags) begin
          failures++;
          $display("FAIL %s dut%0d flags got=%b want=%b", e.name, e.sel, obs_flags[e.sel], e.flags);
        end
        checks++;
        if (obs_cnt[e.sel] !== e.cnt) begin
          failures++;
          $display("FAIL %s dut%0d count got=%0d want=%0d", e.name, e.sel, obs_cnt[e.sel], e.cnt);
        end
      end
    end
    // Hazard inputs remain asserted while reset is driven low mid-cycle.
    Reset_n = 1'b0;
    push(3, NORM_F, 16'd0, "sat_reset");
    push(1, NORM_F, 16'd0, "sat_reset");
    #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_flags[e.sel] !== e.flags) begin
        failures++;
        $display("FAIL %s dut%0d flags got=%b want=%b", e.name, e.sel, obs_flags[e.sel], e.flags);
      end
      checks++;
      if (obs_cnt[e.sel] !== e.cnt) begin
        failures++;
        $display("FAIL %s dut%0d count got=%0d want=%0d", e.name, e.sel, obs_cnt[e.sel], e.cnt);
      end
    end
    drive(idle());
    Reset_n = 1'b1;
  endtask

  // Reset in the middle of LOAD_STALL and of MEM_WAIT abandons the sequence.
  task automatic test_reset_mid();
    stim_t       st [6];
    logic [5:0]  ef [6];
    logic [15:0] ec [6];
    exp_t        e;
    do_reset();
    st = '{mk(1'b1, 5'd7, 5'd7, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0), idle(), idle(),
           mk(1'b1, 5'd7, 5'd7, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0),
           mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0), idle()};
    ef = '{STALL_F, STALL_F, NORM_F, STALL_F, FREEZE_F, NORM_F};
    ec = '{16'd0, 16'd1, 16'd0, 16'd0, 16'd1, 16'd0};
    for (int i = 0; i < 6; i++) begin
      drive(st[i]);
      if (i == 2 || i == 5) Reset_n = 1'b1;
      push(1, ef[i], ec[i], $sformatf("rstmid[%0d]", i));
      #1;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (obs_flags[e.sel] !== e.flags) begin
          failures++;
          $display("FAIL %s dut%0d flags got=%b want=%b", e.name, e.sel, obs_flags[e.sel], e.flags);
        end
        checks++;
        if (obs_cnt[e.sel] !== e.cnt) begin
          failures++;
          $display("FAIL %s dut%0d count got=%0d want=%0d", e.name, e.sel, obs_cnt[e.sel], e.cnt);
        end
      end
      if (i == 1 || i == 4) Reset_n = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_load_lat1();
    test_load_lat3();
    test_zero_skip();
    test_mem_wait();
    test_branch();
    test_saturate();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule

// File: doc/hazard_control_unit.md
HAZARD_CONTROL_UNIT -- requirements
Module: hazard_control_unit

Interface
REQ-001 Parameter REG_W, default 5: register-specifier width.
REQ-002 Parameter LOAD_LAT, default 1, legal 1..8: load-use bubble cycles per hazard.
REQ-003 Parameter CNT_W, default 16: stall-counter width.
REQ-004 Parameter ZERO_SKIP, default 1: when 1, a specifier of 0 never causes a hazard.
REQ-005 Clk  in  1  single clock, rising edge.
REQ-006 Reset_n  in  1  asynchronous, active-low reset.
REQ-007 IF_ID_Rs  in  REG_W  source register of instruction in IF/ID.
REQ-008 IF_ID_Rt  in  REG_W  second source register of instruction in IF/ID.
REQ-009 IF_ID_UsesRt  in  1  IF/ID instruction reads Rt.
REQ-010 ID_EXE_MemRead  in  1  instruction in ID/EX is a load.
REQ-011 ID_EXE_RtReg  in  REG_W  load destination in ID/EX.
REQ-012 Branch_Taken  in  1  branch/jump resolved taken in EX this cycle.
REQ-013 Mem_Ready  in  1  data memory completes access this cycle.
REQ-014 Clear_Count  in  1  synchronous clear of Stall_Count.
REQ-015 Stall  out  1  insert bubble into ID/EX.
REQ-016 PC_Write  out  1  PC update enable.
REQ-017 IF_ID_Write  out  1  IF/ID register write enable.
REQ-018 IF_ID_Flush  out  1  zero IF/ID at next edge.
REQ-019 ID_EXE_Flush  out  1  zero ID/EX at next edge.
REQ-020 Pipe_Freeze  out  1  hold ID/EX, EX/MEM, MEM/WB.
REQ-021 Stall_Count  out  CNT_W  saturating count of lost cycles.

Function
REQ-022 FSM states RUN, LOAD_STALL, MEM_WAIT; outputs are combinational from state and current inputs; state and counters are registered.
REQ-023 Hazard = ID_EXE_MemRead & ((ID_EXE_RtReg==IF_ID_Rs) | (IF_ID_UsesRt & ID_EXE_RtReg==IF_ID_Rt)), masked to 0 when ZERO_SKIP=1 and ID_EXE_RtReg==0.
REQ-024 Priority per cycle: Mem_Ready=0 first, then Branch_Taken, then Hazard/LOAD_STALL, else normal.
REQ-025 Mem_Ready=0 (any state): Pipe_Freeze=1, PC_Write=0, IF_ID_Write=0, Stall=0, both flushes 0; next state MEM_WAIT; bubble counter holds.
REQ-026 MEM_WAIT with Mem_Ready=1: return to the state held before the wait (RUN or LOAD_STALL with preserved count) and evaluate outputs as that state this same cycle.
REQ-027 Branch_Taken=1, Mem_Ready=1: IF_ID_Flush=1, ID_EXE_Flush=1, PC_Write=1, IF_ID_Write=1, Stall=0; any LOAD_STALL is cancelled; next state RUN.
REQ-028 RUN, Hazard=1: Stall=1, PC_Write=0, IF_ID_Write=0; if LOAD_LAT>1 load bubble counter with LOAD_LAT-1, next LOAD_STALL; else stay RUN.
REQ-029 LOAD_STALL: Stall=1, PC_Write=0, IF_ID_Write=0; decrement counter; leave to RUN when counter reaches 0, giving exactly LOAD_LAT stalled cycles per hazard.
REQ-030 Normal: Stall=0, PC_Write=1, IF_ID_Write=1, flushes 0, Pipe_Freeze=0.
REQ-031 Stall_Count +1 on every cycle with Stall=1 or Pipe_Freeze=1; saturates at 2^CNT_W-1; Clear_Count wins over increment (result 0).

Reset
REQ-032 Reset_n=0 asynchronously forces RUN, bubble counter 0, Stall_Count 0; outputs then Stall=0, PC_Write=1, IF_ID_Write=1, flushes 0, Pipe_Freeze=0.
REQ-033 Reset assertion mid-LOAD_STALL or MEM_WAIT abandons the sequence; first cycle after release is RUN.

Verification
REQ-034 LOAD_LAT=1: MemRead=1, RtReg=5, Rs=5 -> one cycle Stall=1, PC_Write=0; next cycle (MemRead=0) normal; Stall_Count=1.
REQ-035 LOAD_LAT=3: RtReg=7, Rt=7, UsesRt=1 -> Stall=1 for exactly 3 cycles; UsesRt=0 -> no stall.
REQ-036 ZERO_SKIP=1: MemRead=1, RtReg=0, Rs=0 -> no stall; ZERO_SKIP=0 -> 1-cycle stall.
REQ-037 LOAD_LAT=3, Mem_Ready=0 for 2 cycles during 2nd stall cycle -> Pipe_Freeze 2 cycles, then 2 remaining stall cycles; Stall_Count=5.
REQ-038 Branch_Taken=1 coincident with LOAD_STALL -> both flushes 1, PC_Write=1, next cycle RUN normal.
REQ-039 CNT_W=4: 20 stall cycles -> Stall_Count=15; Clear_Count with stall -> 0; Reset_n low mid-stall -> reset values immediately.
